// File: rtl/despachador_salida_if.sv
// Bundle between the vending FSM and the output dispatcher: result strobe in, actuator drives and status out.
interface despachador_salida_if;
    logic       listo;
    logic [1:0] producto;
    logic [1:0] cambio;
    logic [2:0] motor;
    logic       moneda_out;
    logic       ocupado;
    logic       hecho;
    logic       error_solapado;

    modport master (
        output listo, producto, cambio,
        input  motor, moneda_out, ocupado, hecho, error_solapado
    );

    modport slave (
        input  listo, producto, cambio,
        output motor, moneda_out, ocupado, hecho, error_solapado
    );
endinterface

// File: rtl/despachador_salida.sv
// Output dispatcher: turns one vending result into a timed slot-motor run followed by one coin pulse per change unit.
module despachador_salida #(
    parameter int MOTOR_CYCLES = 8,
    parameter int COIN_PULSE   = 4,
    parameter int COIN_GAP     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    despachador_salida_if.slave  bus
);
    localparam int MAXC = (MOTOR_CYCLES > COIN_PULSE)
                        ? ((MOTOR_CYCLES > COIN_GAP) ? MOTOR_CYCLES : COIN_GAP)
                        : ((COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP);
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] LOAD_MOTOR = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_PULSE = CW'(COIN_PULSE - 1);
    localparam logic [CW-1:0] LOAD_GAP   = CW'(COIN_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOTOR,
        COIN_ON,
        COIN_OFF,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      prod_q, prod_d;
    logic [1:0]      coins_q, coins_d;
    logic [2:0]      motor_q, motor_d;
    logic            moneda_q, moneda_d;
    logic            ocupado_q, ocupado_d;
    logic            hecho_q, hecho_d;
    logic            err_q, err_d;

    // Counters hold "cycles left minus one" so a phase ends when they reach zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        coins_d = coins_q;

        case (state_q)
            IDLE: begin
                if (bus.listo) begin
                    prod_d  = bus.producto;
                    coins_d = bus.cambio;
                    if (bus.producto != 2'b00) begin
                        state_d = MOTOR;
                        cnt_d   = LOAD_MOTOR;
                    end else if (bus.cambio != 2'b00) begin
                        state_d = COIN_ON;
                        cnt_d   = LOAD_PULSE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            MOTOR: begin
                if (cnt_q == '0) begin
                    if (coins_q != 2'b00) begin
                        state_d = COIN_ON;
                        cnt_d   = LOAD_PULSE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            COIN_ON: begin
                if (cnt_q == '0) begin
                    coins_d = coins_q - 2'd1;
                    if (coins_q > 2'd1) begin
                        state_d = COIN_OFF;
                        cnt_d   = LOAD_GAP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            COIN_OFF: begin
                if (cnt_q == '0) begin
                    state_d = COIN_ON;
                    cnt_d   = LOAD_PULSE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered drive lines up with the state it belongs to.
    always_comb begin
        motor_d = 3'b000;
        if (state_d == MOTOR) begin
            case (prod_d)
                2'b01:   motor_d = 3'b001;
                2'b10:   motor_d = 3'b010;
                2'b11:   motor_d = 3'b100;
                default: motor_d = 3'b000;
            endcase
        end
        moneda_d  = (state_d == COIN_ON);
        hecho_d   = (state_d == DONE);
        ocupado_d = (state_d == MOTOR) || (state_d == COIN_ON) || (state_d == COIN_OFF);
        err_d     = bus.listo && (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prod_q    <= 2'b00;
            coins_q   <= 2'b00;
            motor_q   <= 3'b000;
            moneda_q  <= 1'b0;
            ocupado_q <= 1'b0;
            hecho_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            coins_q   <= coins_d;
            motor_q   <= motor_d;
            moneda_q  <= moneda_d;
            ocupado_q <= ocupado_d;
            hecho_q   <= hecho_d;
            err_q     <= err_d;
        end
    end

    assign bus.motor          = motor_q;
    assign bus.moneda_out     = moneda_q;
    assign bus.ocupado        = ocupado_q;
    assign bus.hecho          = hecho_q;
    assign bus.error_solapado = err_q;
endmodule

// File: tb/tb_despachador_salida.sv
// Directed bench for despachador_salida: a cycle-by-cycle expected trace is queued per transaction and drained against the DUT.
module tb_despachador_salida;
    logic clk;
    logic rst;

    despachador_salida_if bus1 ();
    despachador_salida_if bus2 ();

    despachador_salida dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    despachador_salida #(
        .MOTOR_CYCLES (1),
        .COIN_PULSE   (1),
        .COIN_GAP     (1)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] motor;
        logic       moneda;
        logic       hecho;
        logic       err;
        logic       ocp;
        bit         chkOcp;
    } exp_t;

    exp_t sb[$];
    int   passCount = 0;
    int   totalCount = 0;
    int   modelT;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        totalCount++;
        assert (obs === expv) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic pushEntry(input logic [2:0] m, input logic mo, input logic h,
                             input logic o, input bit co, input int errAt);
        exp_t e;
        e.motor  = m;
        e.moneda = mo;
        e.hecho  = h;
        e.ocp    = o;
        e.chkOcp = co;
        e.err    = (modelT == errAt);
        sb.push_back(e);
        modelT++;
    endtask

    // Reference trace: motor phase, coin pulses with gaps between them, one DONE cycle, then idle.
    task automatic pushTx(input logic [1:0] p, input logic [1:0] c,
                          input int mc, input int pc, input int gc, input int errAt);
        logic [2:0] oh;
        oh = (p == 2'b01) ? 3'b001 : (p == 2'b10) ? 3'b010 : 3'b100;
        modelT = 1;
        if (p != 2'b00)
            for (int i = 0; i < mc; i++) pushEntry(oh, 1'b0, 1'b0, 1'b1, 1'b1, errAt);
        for (int k = 0; k < int'(c); k++) begin
            for (int i = 0; i < pc; i++) pushEntry(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, errAt);
            if (k < int'(c) - 1)
                for (int i = 0; i < gc; i++) pushEntry(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, errAt);
        end
        pushEntry(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, errAt);
        for (int i = 0; i < 2; i++) pushEntry(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, errAt);
    endtask

    task automatic applyStimulus(input int sel, input logic [1:0] p, input logic [1:0] c);
        @(negedge clk);
        if (sel == 0) begin
            bus1.listo = 1'b1; bus1.producto = p; bus1.cambio = c;
        end else begin
            bus2.listo = 1'b1; bus2.producto = p; bus2.cambio = c;
        end
        @(negedge clk);
        bus1.listo = 1'b0;
        bus2.listo = 1'b0;
    endtask

    // Drains the queue one cycle at a time; optionally fires an overlapping request on dut1.
    task automatic checkOutput(input string tag, input int sel, input int injectAt);
        exp_t e;
        int   cyc;
        logic [7:0] obs;
        logic [7:0] expv;
        cyc = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (sel == 0)
                obs = {3'b000, bus1.motor, bus1.moneda_out, bus1.hecho, bus1.error_solapado};
            else
                obs = {3'b000, bus2.motor, bus2.moneda_out, bus2.hecho, bus2.error_solapado};
            expv = {3'b000, e.motor, e.moneda, e.hecho, e.err};
            chk($sformatf("%s c%0d out", tag, cyc), obs, expv);
            if (e.chkOcp)
                chk($sformatf("%s c%0d ocupado", tag, cyc),
                    {7'b0, (sel == 0) ? bus1.ocupado : bus2.ocupado}, {7'b0, e.ocp});
            bus1.listo = (cyc == injectAt);
            if (cyc == injectAt) begin
                bus1.producto = 2'b11;
                bus1.cambio   = 2'b11;
            end
            @(negedge clk);
            cyc++;
        end
        bus1.listo = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus1.listo = 1'b0; bus1.producto = 2'b00; bus1.cambio = 2'b00;
        bus2.listo = 1'b0; bus2.producto = 2'b00; bus2.cambio = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset outputs dut1",
            {3'b000, bus1.motor, bus1.moneda_out, bus1.ocupado, bus1.hecho, bus1.error_solapado}, 8'h00);
        chk("reset outputs dut2",
            {3'b000, bus2.motor, bus2.moneda_out, bus2.ocupado, bus2.hecho, bus2.error_solapado}, 8'h00);

        $display("[TB] slot B, no change");
        pushTx(2'b10, 2'b00, 8, 4, 4, -1);
        applyStimulus(0, 2'b10, 2'b00);
        checkOutput("pB_c0", 0, 0);

        $display("[TB] slot A, three coins");
        pushTx(2'b01, 2'b11, 8, 4, 4, -1);
        applyStimulus(0, 2'b01, 2'b11);
        checkOutput("pA_c3", 0, 0);

        $display("[TB] no product, two coins");
        pushTx(2'b00, 2'b10, 8, 4, 4, -1);
        applyStimulus(0, 2'b00, 2'b10);
        checkOutput("p0_c2", 0, 0);

        $display("[TB] empty transaction");
        pushTx(2'b00, 2'b00, 8, 4, 4, -1);
        applyStimulus(0, 2'b00, 2'b00);
        checkOutput("p0_c0", 0, 0);

        $display("[TB] overlapping request during motor");
        pushTx(2'b01, 2'b01, 8, 4, 4, 4);
        applyStimulus(0, 2'b01, 2'b01);
        checkOutput("overlap", 0, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("overlap dropped c%0d", i),
                {3'b000, bus1.motor, bus1.moneda_out, bus1.ocupado, bus1.hecho, bus1.error_solapado}, 8'h00);
            @(negedge clk);
        end

        $display("[TB] minimal timing, slot C, three coins");
        pushTx(2'b11, 2'b11, 1, 1, 1, -1);
        applyStimulus(1, 2'b11, 2'b11);
        checkOutput("min_pC_c3", 1, 0);

        $display("[TB] reset during coin pulse");
        applyStimulus(0, 2'b00, 2'b10);
        @(negedge clk);
        chk("pre-reset moneda", {7'b0, bus1.moneda_out}, 8'h01);
        chk("pre-reset ocupado", {7'b0, bus1.ocupado}, 8'h01);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset moneda", {7'b0, bus1.moneda_out}, 8'h00);
        chk("async reset motor", {5'b0, bus1.motor}, 8'h00);
        chk("async reset ocupado", {7'b0, bus1.ocupado}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset idle c%0d", i),
                {3'b000, bus1.motor, bus1.moneda_out, bus1.ocupado, bus1.hecho, bus1.error_solapado}, 8'h00);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
